countdown_sequencer: RTL and testbench



---
 rtl/countdown_pkg.sv | 15 +
 rtl/tick_prescaler.sv | 36 +++
 rtl/countdown_sequencer.sv | 130 +++++++++++++
 tb/tb_countdown_sequencer.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the countdown sequencer.
// Build option: COUNTDOWN_AUTO_RELOAD_EN (see countdown_sequencer.sv).
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int CNT_W            = 6;
  localparam int DEFAULT_TICK_DIV = 50_000_000;

endpackage

// File: rtl/tick_prescaler.sv
// Divides the clock into a one-cycle tick every DIV enabled cycles.
// The count holds while en is low, so a paused run resumes mid-period.
module tick_prescaler #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          at_last;

  assign at_last = (cnt_q == LAST);
  assign tick    = en & at_last;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_last ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/countdown_sequencer.sv
// Button-driven countdown FSM with prescaled decrement.
// Define COUNTDOWN_AUTO_RELOAD_EN to reload from initial_value at zero.
module countdown_sequencer
  import countdown_pkg::*;
#(
  parameter int WIDTH    = CNT_W,
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             pause,
  input  logic             clear,
  input  logic [WIDTH-1:0] initial_value,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             paused,
  output logic             done,
  output logic [1:0]       state_dbg
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             start_q, pause_q, clear_q;
  logic             running_q, paused_q, done_q;
  logic             start_rise, pause_rise, clear_rise;
  logic             tick, presc_en, presc_clr, reload;

  assign start_rise = start & ~start_q;
  assign pause_rise = pause & ~pause_q;
  assign clear_rise = clear & ~clear_q;

  assign presc_en  = (state_q == RUN);
  assign presc_clr = (state_q == IDLE) | clear_rise;

  tick_prescaler #(
    .DIV (TICK_DIV)
  ) u_presc (
    .clk   (clk),
    .reset (reset),
    .en    (presc_en),
    .clr   (presc_clr),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    reload  = 1'b0;
    unique case (state_q)
      IDLE: begin
        count_d = initial_value;
        if (start_rise) begin
          state_d = (initial_value == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (clear_rise) begin
          state_d = IDLE;
        end else begin
          // Decrement is applied before a coincident pause is honoured.
          if (tick && count_q != '0) begin
            if (count_q == WIDTH'(1)) begin
`ifdef COUNTDOWN_AUTO_RELOAD_EN
              if (initial_value == '0) begin
                count_d = '0;
                state_d = DONE;
              end else begin
                count_d = initial_value;
                reload  = 1'b1;
              end
`else
              count_d = '0;
              state_d = DONE;
`endif
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
          if (pause_rise && state_d == RUN) begin
            state_d = PAUSE;
          end
        end
      end
      PAUSE: begin
        if (clear_rise) begin
          state_d = IDLE;
        end else if (pause_rise || start_rise) begin
          state_d = RUN;
        end
      end
      DONE: begin
        count_d = '0;
        if (clear_rise || start_rise) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      start_q   <= 1'b0;
      pause_q   <= 1'b0;
      clear_q   <= 1'b0;
      running_q <= 1'b0;
      paused_q  <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      start_q   <= start;
      pause_q   <= pause;
      clear_q   <= clear;
      running_q <= (state_d == RUN);
      paused_q  <= (state_d == PAUSE);
      done_q    <= (state_d == DONE) | reload;
    end
  end

  assign count     = count_q;
  assign running   = running_q;
  assign paused    = paused_q;
  assign done      = done_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_countdown_sequencer.sv
// Directed bench for countdown_sequencer with TICK_DIV=4.
// Honours COUNTDOWN_AUTO_RELOAD_EN for the zero-reaching cases.
module tb_countdown_sequencer;

  localparam int W = 6;

  typedef struct {
    logic         st;
    logic         pa;
    logic         cl;
    logic [W-1:0] iv;
    logic [W-1:0] ecnt;
    logic [1:0]   est;
    logic [2:0]   eflg;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset, start, pause, clear;
  logic [W-1:0] initial_value;
  logic [W-1:0] count;
  logic         running, paused, done;
  logic [1:0]   state_dbg;

  int n_chk  = 0;
  int n_fail = 0;
  vec_t tbl[$];

  localparam logic [2:0] F_NONE = 3'b000;
  localparam logic [2:0] F_RUN  = 3'b100;
  localparam logic [2:0] F_PAU  = 3'b010;
  localparam logic [2:0] F_DONE = 3'b001;

  countdown_sequencer #(
    .WIDTH    (W),
    .TICK_DIV (4)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .start         (start),
    .pause         (pause),
    .clear         (clear),
    .initial_value (initial_value),
    .count         (count),
    .running       (running),
    .paused        (paused),
    .done          (done),
    .state_dbg     (state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cs(input string nm, input logic [W-1:0] ec,
                    input logic [1:0] es, input logic [2:0] ef);
    chk({nm, " count"}, 32'(count), 32'(ec));
    chk({nm, " state"}, 32'(state_dbg), 32'(es));
    chk({nm, " flags"}, 32'({running, paused, done}), 32'(ef));
  endtask

  task automatic add(input logic s, input logic p, input logic c,
                     input logic [W-1:0] iv, input logic [W-1:0] ec,
                     input logic [1:0] es, input logic [2:0] ef);
    vec_t v;
    v.st = s; v.pa = p; v.cl = c; v.iv = iv;
    v.ecnt = ec; v.est = es; v.eflg = ef;
    tbl.push_back(v);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; pause = 1'b0; clear = 1'b0;
    initial_value = 6'd3;

    // basic countdown, one row per clock edge
    add(1'b1, 1'b0, 1'b0, 6'd3, 6'd3, 2'd1, F_RUN);
    add(1'b1, 1'b0, 1'b0, 6'd3, 6'd3, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd3, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd3, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd2, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd2, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd2, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd2, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd1, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd1, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd1, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd1, 2'd1, F_RUN);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd3, 2'd1, F_RUN | F_DONE);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd3, 2'd1, F_RUN);
    add(1'b0, 1'b0, 1'b1, 6'd3, 6'd3, 2'd0, F_NONE);
`else
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd0, 2'd3, F_DONE);
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd0, 2'd3, F_DONE);
    add(1'b0, 1'b0, 1'b1, 6'd3, 6'd0, 2'd0, F_NONE);
`endif
    add(1'b0, 1'b0, 1'b0, 6'd3, 6'd3, 2'd0, F_NONE);

    step(2);
    cs("reset", 6'd0, 2'd0, F_NONE);
    reset = 1'b0;
    step(1);
    cs("idle preview", 6'd3, 2'd0, F_NONE);

    foreach (tbl[i]) begin
      start = tbl[i].st;
      pause = tbl[i].pa;
      clear = tbl[i].cl;
      initial_value = tbl[i].iv;
      step(1);
      cs($sformatf("basic row%0d", i), tbl[i].ecnt, tbl[i].est,
         tbl[i].eflg);
    end

    // zero start goes straight to DONE
    initial_value = 6'd0;
    step(1);
    start = 1'b1;
    step(1);
    cs("zero start", 6'd0, 2'd3, F_DONE);
    start = 1'b0; clear = 1'b1;
    step(1);
    cs("zero clear", 6'd0, 2'd0, F_NONE);
    clear = 1'b0;

    // pause / resume keeps prescaler phase
    initial_value = 6'd5;
    step(1);
    start = 1'b1;
    step(1);
    cs("pr start", 6'd5, 2'd1, F_RUN);
    start = 1'b0;
    step(1);
    pause = 1'b1;
    step(1);
    cs("pr pause", 6'd5, 2'd2, F_PAU);
    pause = 1'b0;
    step(10);
    cs("pr hold", 6'd5, 2'd2, F_PAU);
    pause = 1'b1;
    step(1);
    cs("pr resume", 6'd5, 2'd1, F_RUN);
    pause = 1'b0;
    step(1);
    cs("pr resume+1", 6'd5, 2'd1, F_RUN);
    step(1);
    cs("pr first dec", 6'd4, 2'd1, F_RUN);
    clear = 1'b1;
    step(1);
    cs("pr clear", 6'd4, 2'd0, F_NONE);
    clear = 1'b0;
    step(1);
    cs("pr idle", 6'd5, 2'd0, F_NONE);

    // clear beats pause
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    clear = 1'b1; pause = 1'b1;
    step(1);
    cs("clr+pause", 6'd5, 2'd0, F_NONE);
    clear = 1'b0; pause = 1'b0;
    step(1);

    // held start is a single event
    initial_value = 6'd2;
    step(1);
    start = 1'b1;
    step(1);
    cs("held start e0", 6'd2, 2'd1, F_RUN);
    step(19);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    cs("held start end", 6'd2, 2'd1, F_RUN);
`else
    cs("held start end", 6'd0, 2'd3, F_DONE);
`endif
    start = 1'b0; clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);

    // final tick coincides with pause
    initial_value = 6'd1;
    step(1);
    start = 1'b1;
    step(1);
    cs("tp start", 6'd1, 2'd1, F_RUN);
    start = 1'b0;
    step(3);
    pause = 1'b1;
    step(1);
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    cs("tick+pause", 6'd1, 2'd2, F_PAU | F_DONE);
`else
    cs("tick+pause", 6'd0, 2'd3, F_DONE);
`endif
    pause = 1'b0; clear = 1'b1;
    step(1);
    clear = 1'b0;
    step(1);

    // reset in the middle of a run
    initial_value = 6'd5;
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(4);
    cs("pre reset", 6'd4, 2'd1, F_RUN);
    initial_value = 6'd7;
    reset = 1'b1;
    step(1);
    cs("mid reset", 6'd0, 2'd0, F_NONE);
    reset = 1'b0;
    step(1);
    cs("post reset", 6'd7, 2'd0, F_NONE);
    start = 1'b1;
    step(1);
    cs("rr start", 6'd7, 2'd1, F_RUN);
    start = 1'b0;
    step(3);
    cs("rr e3", 6'd7, 2'd1, F_RUN);
    step(1);
    cs("rr first dec", 6'd6, 2'd1, F_RUN);
    clear = 1'b1;
    step(1);
    clear = 1'b0;

    // button held through reset gives one edge
    reset = 1'b1; start = 1'b1; initial_value = 6'd3;
    step(1);
    reset = 1'b0;
    step(1);
    cs("held thru reset", 6'd3, 2'd1, F_RUN);
    clear = 1'b1;
    step(1);
    cs("htr clear", 6'd3, 2'd0, F_NONE);
    clear = 1'b0; start = 1'b0;
    step(1);

`ifdef COUNTDOWN_AUTO_RELOAD_EN
    initial_value = 6'd2;
    step(1);
    start = 1'b1;
    step(1);
    cs("ar start", 6'd2, 2'd1, F_RUN);
    start = 1'b0;
    step(4);
    cs("ar e4", 6'd1, 2'd1, F_RUN);
    step(3);
    cs("ar e7", 6'd1, 2'd1, F_RUN);
    step(1);
    cs("ar reload", 6'd2, 2'd1, F_RUN | F_DONE);
    step(1);
    cs("ar pulse end", 6'd2, 2'd1, F_RUN);
    step(3);
    cs("ar e12", 6'd1, 2'd1, F_RUN);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
